mem_fill_dma: RTL
=================

MEM_FILL_DMA -- requirements
Module: mem_fill_dma

Interface
REQ-001 Parameter: TIMEOUT, default 255, max clk cycles from request assertion to first membusy=1 before an error is declared.
REQ-002 clk  input  1  system clock (clk75 domain), all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a transfer; ignored unless idle.
REQ-005 base_addr  input  18  first word address, sampled on start.
REQ-006 len_bytes  input  19  number of bytes to transfer, sampled on start.
REQ-007 src_data  input  8  byte from the source stream, e.g. the SD reader.
REQ-008 src_valid  input  1  src_data valid.
REQ-009 src_ready  output  1  byte consumed when src_valid & src_ready.
REQ-010 iaddr  output  18  memory word address.
REQ-011 dataw  output  16  memory write data.
REQ-012 rd  output  1  read request, held 0 (write-only initiator).
REQ-013 we_n  output  1  write request, active low.
REQ-014 ilb_n / iub_n  output  1 each  low/high byte enables, active low.
REQ-015 membusy  input  1  responder busy flag.
REQ-016 busy  output  1  transfer in progress.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 error  output  1  sticky timeout flag, cleared by the next accepted start.

Function
REQ-019 States: IDLE, GET_LO, GET_HI, WR_REQ, WR_WAIT, FIN, ERR.
REQ-020 IDLE: on start, latch base_addr and len_bytes and clear error; go to FIN if len_bytes==0, else GET_LO.
REQ-021 GET_LO: src_ready=1; on a byte, store it in dataw[7:0] and decrement remaining; go to WR_REQ with iub_n=1 if remaining becomes 0, else GET_HI.
REQ-022 GET_HI: src_ready=1; on a byte, store it in dataw[15:8], decrement remaining, set ilb_n=iub_n=0, go to WR_REQ.
REQ-023 Little-endian packing: even byte to low half, odd byte to high half; src_ready=0 in all other states.
REQ-024 WR_REQ: drive we_n=0 with iaddr, dataw and enables registered and stable; wait for membusy=1, then go to WR_WAIT.
REQ-025 WR_WAIT: hold all request outputs; on the first cycle membusy=0, the write is complete; we_n=1 on the next cycle.
REQ-026 After completion, word address +1 modulo 2^18 (wraps 0x3FFFF->0x00000); go to GET_LO if bytes remain, else FIN.
REQ-027 Timeout counter: cleared on entry to WR_REQ, increments each WR_REQ cycle with membusy=0; reaching TIMEOUT -> ERR with we_n=1.
REQ-028 No timeout in WR_WAIT.
REQ-029 FIN: done=1 for one cycle, then IDLE.
REQ-030 ERR: set error, busy=0, then IDLE.
REQ-031 busy=1 in all states except IDLE.
REQ-032 Start asserted in any non-IDLE state has no effect.
REQ-033 we_n shall never be low in the same cycle as rd=1, and never low in GET_LO, GET_HI, FIN, ERR or IDLE.
REQ-034 At most one write is outstanding; a new request needs we_n high for at least one cycle first.
REQ-035 Odd len_bytes: final write uses ilb_n=0, iub_n=1; dataw[15:8] holds its previous value, don't-care to the responder.
REQ-036 membusy=1 already present on entry to WR_REQ counts as acceptance.

Reset
REQ-037 reset_n low, at any time including mid-write: state IDLE, we_n=1, rd=0, ilb_n=iub_n=1, iaddr=0, dataw=0, src_ready=0, busy=0, done=0, error=0, counters 0.
REQ-038 No partial request resumes after reset release.

Verification
REQ-039 base=0x02000, len=4, bytes 11 22 33 44, responder busy 3 cycles per write -> writes 0x2211@0x02000 and 0x4433@0x02001, both enables low, single done pulse.
REQ-040 len=3, bytes AA BB CC -> 0xBBAA@base, then a final write with low byte 0xCC, ilb_n=0, iub_n=1; done once.
REQ-041 base=0x3FFFF, len=4 -> writes at 0x3FFFF then 0x00000.
REQ-042 TIMEOUT=8, membusy held 0 -> we_n low exactly 8 cycles, then error=1, busy=0, no done.
REQ-043 len=0 -> no write, no src_ready, done 2 cycles after start; a second start while busy is ignored.
REQ-044 reset_n pulsed low during WR_WAIT -> all outputs return to REQ-037 values asynchronously; a new start after release runs a full transfer.

Source files
------------

// File: rtl/mem_fill_dma.sv
// mem_fill_dma: write-only DMA that packs a byte stream into 16-bit words
// and writes them to consecutive word addresses of a busy-handshaked memory.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, accepted only when idle
//   base_addr, len_bytes  first word address and byte count, latched on start
//   src_data, src_valid   byte stream in; src_ready marks consumption
//   iaddr, dataw          word address and write data (registered)
//   rd                    tied low, this initiator never reads
//   we_n, ilb_n, iub_n    active-low write strobe and low/high byte enables
//   membusy               responder busy; 1 = write accepted, falling = done
//   busy, done, error     in progress, completion pulse, sticky timeout flag
module mem_fill_dma #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [17:0] base_addr,
   input  logic [18:0] len_bytes,
   input  logic [7:0]  src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [17:0] iaddr,
   output logic [15:0] dataw,
   output logic        rd,
   output logic        we_n,
   output logic        ilb_n,
   output logic        iub_n,
   input  logic        membusy,
   output logic        busy,
   output logic        done,
   output logic        error
);

   // Counter only has to reach TIMEOUT-1: the timeout fires on the cycle
   // that would make it TIMEOUT.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_LO, S_GET_HI, S_WR_REQ, S_WR_WAIT, S_FIN, S_ERR
   } state_t;

   state_t        state, state_nx;
   logic [17:0]   addr_q, addr_nx;
   logic [18:0]   rem_q, rem_nx;
   logic [15:0]   data_q, data_nx;
   logic          ilb_q, ilb_nx;
   logic          iub_q, iub_nx;
   logic [CW-1:0] tcnt_q, tcnt_nx;
   logic          err_q, err_nx;
   logic          we_n_q, src_ready_q, busy_q, done_q;
   logic          take;

   assign take = src_valid & src_ready_q;

   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      rem_nx   = rem_q;
      data_nx  = data_q;
      ilb_nx   = ilb_q;
      iub_nx   = iub_q;
      tcnt_nx  = tcnt_q;
      err_nx   = err_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               addr_nx  = base_addr;
               rem_nx   = len_bytes;
               err_nx   = 1'b0;
               state_nx = (len_bytes == '0) ? S_FIN : S_GET_LO;
            end
         end
         S_GET_LO: begin
            if (take) begin
               data_nx[7:0] = src_data;
               rem_nx       = rem_q - 19'd1;
               if (rem_q == 19'd1) begin
                  // last byte of an odd-length transfer: low lane only
                  ilb_nx   = 1'b0;
                  iub_nx   = 1'b1;
                  tcnt_nx  = '0;
                  state_nx = S_WR_REQ;
               end else begin
                  state_nx = S_GET_HI;
               end
            end
         end
         S_GET_HI: begin
            if (take) begin
               data_nx[15:8] = src_data;
               rem_nx        = rem_q - 19'd1;
               ilb_nx        = 1'b0;
               iub_nx        = 1'b0;
               tcnt_nx       = '0;
               state_nx      = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            // acceptance wins over timeout, including membusy already high
            if (membusy) begin
               state_nx = S_WR_WAIT;
            end else if (tcnt_q == TLAST) begin
               err_nx   = 1'b1;
               state_nx = S_ERR;
            end else begin
               tcnt_nx = tcnt_q + CW'(1);
            end
         end
         S_WR_WAIT: begin
            if (!membusy) begin
               addr_nx  = addr_q + 18'd1;
               state_nx = (rem_q != '0) ? S_GET_LO : S_FIN;
            end
         end
         S_FIN:   state_nx = S_IDLE;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they change only on
   // clock edges; busy drops already in ERR so it coincides with error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         data_q      <= '0;
         ilb_q       <= 1'b1;
         iub_q       <= 1'b1;
         tcnt_q      <= '0;
         err_q       <= 1'b0;
         we_n_q      <= 1'b1;
         src_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         addr_q      <= addr_nx;
         rem_q       <= rem_nx;
         data_q      <= data_nx;
         ilb_q       <= ilb_nx;
         iub_q       <= iub_nx;
         tcnt_q      <= tcnt_nx;
         err_q       <= err_nx;
         we_n_q      <= !((state_nx == S_WR_REQ) || (state_nx == S_WR_WAIT));
         src_ready_q <= (state_nx == S_GET_LO) || (state_nx == S_GET_HI);
         busy_q      <= (state_nx != S_IDLE) && (state_nx != S_ERR);
         done_q      <= (state_nx == S_FIN);
      end
   end

   assign src_ready = src_ready_q;
   assign iaddr     = addr_q;
   assign dataw     = data_q;
   assign rd        = 1'b0;
   assign we_n      = we_n_q;
   assign ilb_n     = ilb_q;
   assign iub_n     = iub_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = err_q;

endmodule
